// File: rtl/ra_seq_pkg.sv
// rtl/ra_seq_pkg.sv - state type and default limits shared by the RA step sequencer
`ifndef LOG_ITER
`define LOG_ITER 16
`endif

package ra_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      DRAW,
      EVAL,
      UPDATE,
      CHECK,
      DONE
   } seq_state_e;

   localparam int DEF_LOG_ITER   = `LOG_ITER;
   localparam int DEF_MAX_ITER   = (1 << DEF_LOG_ITER) - 1;
   localparam int DEF_MAX_REDRAW = 64;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable saturating up-counter with a terminal flag
module sat_counter #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_max_o
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_V)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flag looks at the post-update value so callers can act on the edge that reaches MAX.
   assign count_o  = count_q;
   assign at_max_o = (count_d == MAX_V);

endmodule

// File: rtl/ra_step_sequencer.sv
// rtl/ra_step_sequencer.sv - draw/evaluate/update/check sequencer for the random-order async datapath
module ra_step_sequencer
   import ra_seq_pkg::*;
#(
   parameter int LOG_ITER   = DEF_LOG_ITER,
   parameter int MAX_ITER   = (1 << LOG_ITER) - 1,
   parameter int MAX_REDRAW = DEF_MAX_REDRAW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                valid_rule,
   input  logic                steady,
   input  logic                is_steady_state,
   output logic                en_rng,
   output logic                ld_next_state,
   output logic                ld_updated,
   output logic                clr_updated,
   output logic                ld_last_state,
   output logic                steady_state,
   output logic                timeout,
   output logic                fault,
   output logic                busy,
   output logic [LOG_ITER-1:0] iteration_number
);
   localparam int RD_W = $clog2(MAX_REDRAW + 1);

   seq_state_e      state_q;
   logic            steady_q;
   logic            timeout_q;
   logic            fault_q;
   logic            do_abort;
   logic            start_run;
   logic            iter_inc;
   logic            iter_at_max;
   logic            redraw_inc;
   logic            redraw_clr;
   logic            redraw_at_max;
   logic [RD_W-1:0] redraw_count_unused;

   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign do_abort   = abort && busy;
   assign start_run  = (state_q == IDLE) && start;
   assign iter_inc   = (state_q == UPDATE) && !do_abort;
   assign redraw_inc = (state_q == EVAL) && !valid_rule && !do_abort;
   assign redraw_clr = start_run || ((state_q == EVAL) && valid_rule);

   // An abort cycle suppresses every strobe except the clear of the updated bits.
   assign en_rng        = (state_q == DRAW) && !do_abort;
   assign ld_next_state = iter_inc;
   assign ld_updated    = iter_inc;
   assign ld_last_state = iter_inc;
   assign clr_updated   = (state_q == CLR) || ((state_q == CHECK) && !is_steady_state) || do_abort;

   assign steady_state = steady_q;
   assign timeout      = timeout_q;
   assign fault        = fault_q;

   sat_counter #(
      .WIDTH (LOG_ITER),
      .MAX   (MAX_ITER)
   ) u_iter_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (start_run),
      .inc_i    (iter_inc),
      .count_o  (iteration_number),
      .at_max_o (iter_at_max)
   );

   sat_counter #(
      .WIDTH (RD_W),
      .MAX   (MAX_REDRAW)
   ) u_redraw_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (redraw_clr),
      .inc_i    (redraw_inc),
      .count_o  (redraw_count_unused),
      .at_max_o (redraw_at_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         steady_q  <= 1'b0;
         timeout_q <= 1'b0;
         fault_q   <= 1'b0;
      end else if (do_abort) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= CLR;
                  steady_q  <= 1'b0;
                  timeout_q <= 1'b0;
                  fault_q   <= 1'b0;
               end
            end
            CLR:  state_q <= DRAW;
            DRAW: state_q <= EVAL;
            EVAL: begin
               if (valid_rule) begin
                  state_q <= UPDATE;
               end else if (redraw_at_max) begin
                  state_q <= DONE;
                  fault_q <= 1'b1;
               end else begin
                  state_q <= DRAW;
               end
            end
            UPDATE: state_q <= CHECK;
            CHECK: begin
               if (is_steady_state && steady) begin
                  state_q  <= DONE;
                  steady_q <= 1'b1;
               end else if (iter_at_max) begin
                  state_q   <= DONE;
                  timeout_q <= 1'b1;
               end else begin
                  state_q <= DRAW;
               end
            end
            DONE: begin
               if (!start) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
